// File: rtl/count_enable_pkg.sv
// Shared types and default widths for the count-enable generator slice.
// The state enum is used by the FSM in the top and referenced by the bench.
package count_enable_pkg;

  localparam int DEF_PRESCALE_W = 4;
  localparam int DEF_LEN_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/count_enable_gen_if.sv
// Command/status bundle between a controller and count_enable_gen.
// The master drives run commands; the slave (the generator) returns status.
interface count_enable_gen_if
  import count_enable_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int LEN_W      = DEF_LEN_W
);

  logic                  start;
  logic                  stop;
  logic                  pause;
  logic [PRESCALE_W-1:0] prescale;
  logic [LEN_W-1:0]      run_len;
  logic                  enable;
  logic                  busy;
  logic                  done;
  logic [LEN_W-1:0]      ticks;

  modport master (
    output start, stop, pause, prescale, run_len,
    input  enable, busy, done, ticks
  );

  modport slave (
    input  start, stop, pause, prescale, run_len,
    output enable, busy, done, ticks
  );

endinterface

// File: rtl/count_enable_gen_prescaler.sv
// Free-running phase counter 0..terminal that emits a tick on the terminal count.
// Clear restarts the phase; hold freezes it so a paused run resumes where it stopped.
module tick_prescaler
  import count_enable_pkg::*;
#(
  parameter int W = DEF_PRESCALE_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_hold,
  input  logic [W-1:0] i_terminal,
  output logic         o_tick
);

  logic [W-1:0] r_count;
  logic         w_at_term;

  assign w_at_term = (r_count == i_terminal);
  assign o_tick    = !i_clear && !i_hold && w_at_term;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (!i_hold) begin
      r_count <= w_at_term ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/count_enable_gen.sv
// Run controller: issues run_len registered enable pulses spaced prescale+1 cycles
// apart, with pause/stop control, a done pulse and a running pulse count.
module count_enable_gen
  import count_enable_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic               clock,
  input  logic               reset,
  count_enable_gen_if.slave  bus
);

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [LEN_W-1:0]      r_run_len;
  logic [LEN_W-1:0]      r_ticks;
  logic                  r_enable;
  logic                  r_busy;
  logic                  r_done;

  logic w_running;
  logic w_finish;
  logic w_accept;
  logic w_advance;
  logic w_tick;

  assign w_running = (r_state == ST_RUN) || (r_state == ST_HOLD);
  // Completion is checked before pause so a pause during the last pulse cannot stall DONE.
  assign w_finish  = (r_state == ST_RUN) && (r_ticks == r_run_len);
  assign w_accept  = (r_state == ST_IDLE) && bus.start && !bus.stop;
  assign w_advance = w_running && !bus.stop && !w_finish && !bus.pause;

  tick_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_accept),
    .i_hold     (!w_advance),
    .i_terminal (r_prescale),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_prescale <= '0;
      r_run_len  <= '0;
      r_ticks    <= '0;
      r_enable   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_prescale <= bus.prescale;
            r_run_len  <= bus.run_len;
            r_ticks    <= '0;
            if (bus.run_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN, ST_HOLD: begin
          if (bus.stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_finish) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (bus.pause) begin
            r_state <= ST_HOLD;
          end else begin
            r_state  <= ST_RUN;
            r_enable <= w_tick;
            if (w_tick) begin
              r_ticks <= r_ticks + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable = r_enable;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.ticks  = r_ticks;

endmodule

// File: tb/tb_count_enable_gen.sv
// Randomized and directed bench for count_enable_gen: a run-level model predicts
// enable/done events into a queue that an independent monitor drains.
module tb_count_enable_gen;

  typedef struct {
    int cyc;
    int kind;
    int ticks;
  } evt_t;

  localparam int KIND_ENABLE = 1;
  localparam int KIND_DONE   = 2;

  logic       clock = 1'b0;
  logic       reset;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] dsCount = 4'd0;
  evt_t       sbQ[$];

  count_enable_gen_if #(.PRESCALE_W(4), .LEN_W(8)) bus ();

  count_enable_gen #(
    .PRESCALE_W (4),
    .LEN_W      (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Edge counter: after posedge N settles, cyc == N.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every enable/done pulse the DUT shows must match the oldest prediction.
  initial begin
    evt_t expEvt;
    forever begin
      @(posedge clock);
      #1;
      if (bus.enable || bus.done) begin
        if (bus.enable) dsCount = dsCount + 4'd1;
        if (sbQ.size() == 0) begin
          checkOutput("spurious_event", int'({bus.done, bus.enable}), 0);
        end else begin
          expEvt = sbQ.pop_front();
          checkOutput("event_kind", int'({bus.done, bus.enable}), expEvt.kind);
          checkOutput("event_edge", cyc, expEvt.cyc);
          checkOutput("event_ticks", int'(bus.ticks), expEvt.ticks);
        end
      end
    end
  end

  // One run: the model counts un-paused cycles since start; every (p+1)th one is a pulse.
  // abortKind: 0 none, 1 stop once abortAfter pulses issued, 2 async reset at that point.
  task automatic applyStimulus(input int p, input int l, input bit randPause,
                               input int pauseAfter, input int pauseLen,
                               input int abortKind, input int abortAfter);
    int n;
    int active;
    int pauseLeft;
    int t;
    int e;
    bit fin;
    bit pz;
    bit stopNow;
    n = 0;
    active = 0;
    pauseLeft = 0;
    t = 0;
    fin = 1'b0;
    @(negedge clock);
    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.prescale = 4'(p);
    bus.run_len  = 8'(l);
    e = cyc + 1;
    if (l == 0) sbQ.push_back('{e, KIND_DONE, 0});
    @(negedge clock);
    bus.start = 1'b0;
    if (l == 0) begin
      checkOutput("busy_zero_len", int'(bus.busy), 0);
    end else begin
      while (!fin) begin
        t++;
        e = cyc + 1;
        checkOutput("busy_running", int'(bus.busy), 1);
        bus.start    = 1'($urandom_range(0, 1));
        bus.prescale = 4'($urandom);
        bus.run_len  = 8'($urandom);
        pz = randPause ? ($urandom_range(0, 3) == 0) : (pauseLeft > 0);
        if (pauseLeft > 0) pauseLeft--;
        stopNow = (abortKind == 1) && (n == abortAfter);
        bus.pause = pz;
        bus.stop  = stopNow;
        if ((abortKind == 2) && (n == abortAfter)) begin
          bus.start = 1'b0;
          bus.pause = 1'b0;
          #2 reset = 1'b1;
          #1;
          checkOutput("async_reset_enable", int'(bus.enable), 0);
          checkOutput("async_reset_busy", int'(bus.busy), 0);
          checkOutput("async_reset_done", int'(bus.done), 0);
          checkOutput("async_reset_ticks", int'(bus.ticks), 0);
          @(negedge clock);
          reset = 1'b0;
          n = 0;
          fin = 1'b1;
        end else if (stopNow) begin
          fin = 1'b1;
        end else if (n == l) begin
          sbQ.push_back('{e, KIND_DONE, l});
          fin = 1'b1;
        end else if (!pz) begin
          active++;
          if (active % (p + 1) == 0) begin
            n++;
            sbQ.push_back('{e, KIND_ENABLE, n});
            if (pauseAfter == n) pauseLeft = pauseLen;
          end
        end
        if (t > 5000) begin
          checkOutput("run_timeout", t, 5000);
          fin = 1'b1;
        end
        @(negedge clock);
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("idle_busy", int'(bus.busy), 0);
    checkOutput("idle_done", int'(bus.done), 0);
    checkOutput("held_ticks", int'(bus.ticks), n);
    checkOutput("queue_drained", sbQ.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, edge %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p;
    int l;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.prescale = '0;
    bus.run_len  = '0;
    #3;
    checkOutput("reset_enable", int'(bus.enable), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_ticks", int'(bus.ticks), 0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(0, 5, 1'b0, -1, 0, 0, 0);
    applyStimulus(3, 3, 1'b0, -1, 0, 0, 0);
    applyStimulus(2, 4, 1'b0, 2, 6, 0, 0);
    applyStimulus(1, 10, 1'b0, -1, 0, 1, 3);

    // start together with stop while idle must be refused
    @(negedge clock);
    bus.start    = 1'b1;
    bus.stop     = 1'b1;
    bus.prescale = 4'd1;
    bus.run_len  = 8'd5;
    @(negedge clock);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checkOutput("start_with_stop_busy", int'(bus.busy), 0);
    checkOutput("start_with_stop_ticks", int'(bus.ticks), 3);
    @(negedge clock);
    checkOutput("start_with_stop_still_idle", int'(bus.busy), 0);

    applyStimulus(2, 0, 1'b0, -1, 0, 0, 0);
    applyStimulus(0, 8, 1'b0, -1, 0, 2, 2);

    dsCount = 4'd0;
    applyStimulus(0, 20, 1'b0, -1, 0, 0, 0);
    checkOutput("downstream_counter", int'(dsCount), 4);

    repeat (30) begin
      p = $urandom_range(0, 3);
      l = $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0)
        applyStimulus(p, l, 1'($urandom_range(0, 1)), -1, 0, 1, $urandom_range(0, l));
      else
        applyStimulus(p, l, 1'($urandom_range(0, 1)), -1, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
